// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
// Master drives operands and result acceptance; slave returns result and flags.
// Carries no clock or reset; those stay plain ports on the modules.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, borrow, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, borrow, ovf, zero
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, diff = a - b, LSB first, one bit per cycle.
// Latency: result valid exactly WIDTH cycles after the accept edge.
// Backpressure: result held unboundedly until out_ready; no new operands until then.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_subtractor_if.slave   bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic             in_ready_c;
  logic             out_valid_c;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] d_sr;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             a_msb;
  logic             b_msb;

  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic             ovf_q;
  logic             zero_q;

  // Full-subtractor cell on the current LSBs plus the stored borrow.
  logic             d_bit;
  logic             br_nxt;
  logic [WIDTH-1:0] d_nxt;
  logic             last;

  assign d_bit  = a_sr[0] ^ b_sr[0] ^ br;
  assign br_nxt = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
  assign d_nxt  = {d_bit, d_sr[WIDTH-1:1]};
  assign last   = (cnt == CNT_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs; handshakes derive purely from state.
  always_comb begin
    state_nxt   = state;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    case (state)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand capture, serial shifting, and result load on the final bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr     <= '0;
      b_sr     <= '0;
      d_sr     <= '0;
      cnt      <= '0;
      br       <= 1'b0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_sr  <= bus.a;
            b_sr  <= bus.b;
            a_msb <= bus.a[WIDTH-1];
            b_msb <= bus.b[WIDTH-1];
            cnt   <= '0;
            br    <= 1'b0;
          end
        end
        SHIFT: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          d_sr <= d_nxt;
          br   <= br_nxt;
          if (last) begin
            // Park the counter instead of letting it wrap.
            cnt      <= '0;
            diff_q   <= d_nxt;
            borrow_q <= br_nxt;
            zero_q   <= (d_nxt == '0);
            // Overflow only possible when operand signs differ and the
            // result sign disagrees with the minuend.
            ovf_q    <= (a_msb != b_msb) && (d_nxt[WIDTH-1] != a_msb);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.diff      = diff_q;
  assign bus.borrow    = borrow_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomized checks of serial_subtractor at WIDTH = 8.
// Inputs driven 1 time unit after rising edges; outputs sampled there too.
// Each scenario task does its own comparisons and bumps the shared counters.
module tb_serial_subtractor;
  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one operation from IDLE (called 1 unit after an edge with in_ready high).
  // Returns the sampled result and the measured latency (-1 on timeout).
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input int stall,
                        output logic [W-1:0] d, output logic brw, output logic ov,
                        output logic z, output int lat);
    int n;
    bus.a = av;
    bus.b = bv;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a = W'($urandom);
    bus.b = W'($urandom);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (bus.out_valid !== 1'b1) begin
      lat = -1;
      d = 'x; brw = 1'bx; ov = 1'bx; z = 1'bx;
    end else begin
      lat = n;
      d = bus.diff; brw = bus.borrow; ov = bus.ovf; z = bus.zero;
      repeat (stall) begin @(posedge clk); #1; end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    #12;
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.diff, bus.borrow, bus.ovf, bus.zero} !== {1'b1, 1'b0, 8'h00, 3'b000}) begin
      errors++;
      $display("FAIL reset_state got rdy=%b vld=%b diff=%h b=%b o=%b z=%b exp rdy=1 vld=0 diff=00 flags=000",
               bus.in_ready, bus.out_valid, bus.diff, bus.borrow, bus.ovf, bus.zero);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [W-1:0] d; logic brw, ov, z; int lat;
    run_op(8'd100, 8'd37, 0, d, brw, ov, z, lat);
    checks++;
    if (lat !== 8) begin
      errors++; $display("FAIL basic_latency got %0d exp 8", lat);
    end
    checks++;
    if ({d, brw, ov, z} !== {8'h3F, 3'b000}) begin
      errors++; $display("FAIL basic_result got diff=%h b=%b o=%b z=%b exp diff=3f b=0 o=0 z=0", d, brw, ov, z);
    end
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL basic_after_hs got rdy=%b vld=%b exp rdy=1 vld=0", bus.in_ready, bus.out_valid);
    end
    checks++;
    if (bus.diff !== 8'h3F) begin
      errors++; $display("FAIL basic_retain got diff=%h exp 3f", bus.diff);
    end
  endtask

  task automatic test_flags();
    // a, b, diff, borrow, ovf, zero (ovf: signed result outside -128..127)
    logic [W-1:0] ta [4] = '{8'd37, 8'h80, 8'h55, 8'h00};
    logic [W-1:0] tb [4] = '{8'd100, 8'h01, 8'h55, 8'h01};
    logic [W-1:0] td [4] = '{8'hC1, 8'h7F, 8'h00, 8'hFF};
    logic [2:0]   tf [4] = '{3'b100, 3'b010, 3'b001, 3'b100};
    logic [W-1:0] d; logic brw, ov, z; int lat;
    for (int i = 0; i < 4; i++) begin
      run_op(ta[i], tb[i], i, d, brw, ov, z, lat);
      checks++;
      if ({d, brw, ov, z} !== {td[i], tf[i]} || lat !== 8) begin
        errors++;
        $display("FAIL flags_%0d got diff=%h bof=%b%b%b lat=%0d exp diff=%h bof=%b lat=8",
                 i, d, brw, ov, z, lat, td[i], tf[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] d; logic brw, ov, z; int lat; int n;
    bus.a = 8'h12; bus.b = 8'h34; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    checks++;
    if (n !== 8 || {bus.diff, bus.borrow, bus.ovf, bus.zero} !== {8'hDE, 3'b100}) begin
      errors++; $display("FAIL bp_first got lat=%0d diff=%h bof=%b%b%b exp lat=8 diff=de bof=100",
                         n, bus.diff, bus.borrow, bus.ovf, bus.zero);
    end
    // Offer new operands while the result is stalled; they must not be taken.
    bus.a = 8'hAA; bus.b = 8'h11; bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({bus.out_valid, bus.in_ready, bus.diff, bus.borrow, bus.ovf, bus.zero} !== {2'b10, 8'hDE, 3'b100}) begin
        errors++; $display("FAIL bp_hold_%0d got vld=%b rdy=%b diff=%h bof=%b%b%b exp vld=1 rdy=0 diff=de bof=100",
                           i, bus.out_valid, bus.in_ready, bus.diff, bus.borrow, bus.ovf, bus.zero);
      end
    end
    bus.a = 8'hF0; bus.b = 8'h0F; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release got rdy=%b vld=%b exp rdy=1 vld=0", bus.in_ready, bus.out_valid);
    end
    // in_valid is still high, so this is the accept of 0xF0 - 0x0F.
    run_op(8'hF0, 8'h0F, 2, d, brw, ov, z, lat);
    checks++;
    if ({d, brw, ov, z} !== {8'hE1, 3'b000} || lat !== 8) begin
      errors++; $display("FAIL bp_next got diff=%h bof=%b%b%b lat=%0d exp diff=e1 bof=000 lat=8", d, brw, ov, z, lat);
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] d; logic brw, ov, z; int lat; logic seen;
    bus.a = 8'h33; bus.b = 8'h11; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.diff, bus.borrow, bus.ovf, bus.zero} !== {1'b1, 1'b0, 8'h00, 3'b000}) begin
      errors++; $display("FAIL midreset_state got rdy=%b vld=%b diff=%h bof=%b%b%b exp rdy=1 vld=0 diff=00 bof=000",
                         bus.in_ready, bus.out_valid, bus.diff, bus.borrow, bus.ovf, bus.zero);
    end
    #3 rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL midreset_discard got out_valid=1 exp 0");
    end
    // 200 - 55: signed -56 - 55 = -111 fits in 8 bits, so no signed overflow.
    run_op(8'd200, 8'd55, 0, d, brw, ov, z, lat);
    checks++;
    if ({d, brw, ov, z} !== {8'h91, 3'b000} || lat !== 8) begin
      errors++; $display("FAIL midreset_next got diff=%h bof=%b%b%b lat=%0d exp diff=91 bof=000 lat=8", d, brw, ov, z, lat);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] av, bv, d, ed; logic brw, ov, z, eb, eo, ez; int lat, sd; int stall;
    for (int i = 0; i < 1500; i++) begin
      av = W'($urandom);
      bv = W'($urandom);
      stall = (($urandom & 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      sd = int'($signed(av)) - int'($signed(bv));
      ed = W'(int'(av) - int'(bv));
      eb = (int'(av) < int'(bv));
      eo = (sd > 127) || (sd < -128);
      ez = (av == bv);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      run_op(av, bv, stall, d, brw, ov, z, lat);
      checks++;
      if ({d, brw, ov, z} !== {ed, eb, eo, ez} || lat !== 8) begin
        errors++;
        $display("FAIL random_%0d a=%h b=%h got diff=%h bof=%b%b%b lat=%0d exp diff=%h bof=%b%b%b lat=8",
                 i, av, bv, d, brw, ov, z, lat, ed, eb, eo, ez);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_flags();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end
endmodule
